mmio_stall_controller: RTL
==========================

// Module: mmio_stall_controller
// PURPOSE
//  Sequences memory-mapped-I/O writes issued by the memory-transaction stage (stage 4) of the hart.
//  Detects a valid write into the MMIO window, holds the pipeline via 'stall', drives the MMIO
//  write bus from latched copies, and releases the pipeline once the device reports completion.
//  Sits between the hart pipeline registers and the external MMIO write interface.
// PARAMETERS
//  XLEN            32             data/address width
//  MMIO_BASE       32'h0000_0000  first byte address of the MMIO window
//  MMIO_SIZE       32'h0001_0000  window size in bytes; window = [MMIO_BASE, MMIO_BASE+MMIO_SIZE)
//  TIMEOUT_CYCLES  256            max BUSY cycles before forced completion (MMIO_TIMEOUT_EN only)
// PORTS
//  clock                input   1     single clock, all state updates on posedge
//  reset                input   1     synchronous, active-high
//  req_valid            input   1     stage 4 holds a valid instruction with mem w_enable set
//  req_addr             input   XLEN  stage 4 effective address
//  req_w_data           input   XLEN  stage 4 store value
//  req_width            input   2     mem_width_t of the store
//  mmio_write_complete  input   1     device has accepted the current write
//  mmio_enable          output  1     MMIO write strobe, held until completion
//  mmio_addr            output  XLEN  latched address
//  mmio_w_data          output  XLEN  latched data
//  mmio_width           output  2     latched width
//  stall                output  1     hold stages 1-4 (no PC advance, no closure update)
//  req_done             output  1     one-cycle pulse: MMIO write retired
//  timeout_error        output  1     sticky: a write was force-retired by timeout
//  completed_count      output  16    number of retired MMIO writes, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  - Window hit: in_window = (req_addr - MMIO_BASE) < MMIO_SIZE, XLEN-bit unsigned (no overflow).
//  - FSM states IDLE, BUSY, DONE. Reset -> IDLE; all outputs 0, latches 0, counters 0.
//  - IDLE: stall = req_valid & in_window (combinational, same cycle). If set, latch addr/data/width
//    at the edge -> BUSY. Non-window or !req_valid: stall=0, stay IDLE.
//  - BUSY: mmio_enable=1, stall=1, outputs from latches (stable regardless of req_* changes).
//    mmio_write_complete sampled only here; on 1 -> DONE at the edge.
//  - DONE: mmio_enable=0, stall=0, req_done=1, completed_count += 1 at the edge; req_* ignored
//    (the held instruction leaves stage 4 on this edge) -> IDLE unconditionally.
//  - Latency: stall high for >=2 cycles (IDLE detect + >=1 BUSY); minimum request-to-req_done = 2
//    cycles; back-to-back window writes are re-detected in the IDLE cycle following DONE.
//  - mmio_write_complete in IDLE/DONE: ignored, no effect on state or counters.
//  - Reset asserted in BUSY: abandon write; mmio_enable=0 from the next cycle; no req_done; count unchanged.
//  - Non-BUSY states: mmio_addr/mmio_w_data/mmio_width keep the last latched values.
// CONFIGURATION
//  MMIO_TIMEOUT_EN defined: BUSY cycle counter, width $clog2(TIMEOUT_CYCLES+1), cleared on
//    entering BUSY. When the counter reaches TIMEOUT_CYCLES without completion -> DONE; set
//    timeout_error (sticky until reset). req_done pulses and completed_count increments as normal.
//    If completion and timeout occur in the same cycle, completion wins (timeout_error not set).
//  MMIO_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; timeout_error tied to 0.
// TESTING
//  1. req_valid=1, addr=32'h0000_0010, data=32'hDEAD_BEEF; complete at 3rd BUSY cycle -> stall
//     high 4 cycles, mmio_enable high 3 cycles with addr/data stable, one req_done, count=1.
//  2. req_valid=1, addr=32'h0002_0000 (RAM) -> stall=0, mmio_enable=0, state stays IDLE, count=0.
//  3. Two window writes back-to-back, complete after 1 BUSY cycle each -> two req_done pulses
//     3 cycles apart; count=2; second write's data appears on mmio_w_data only in its BUSY.
//  4. Reset asserted on the 2nd BUSY cycle -> next cycle mmio_enable=0, stall=0, req_done never
//     pulses, count=0.
//  5. MMIO_TIMEOUT_EN, TIMEOUT_CYCLES=4, complete never asserted -> DONE after 4 BUSY cycles,
//     timeout_error=1 and sticky; count=1. Without the macro: stall stays high for 1000 cycles.
//  6. complete pulsed while IDLE, then a window write -> no early retirement; normal sequence.

Source files
------------

// File: rtl/mmio_stall_controller.sv
// -----------------------------------------------------------------------------
// mmio_stall_controller
//
// Sequences memory-mapped-I/O writes issued by the memory-transaction stage
// (stage 4) of the hart. A valid store whose address falls inside the MMIO
// window stalls the pipeline. Address, data and width are captured, and the
// write is driven onto the MMIO write bus from those captured copies. The
// pipeline is released once the device reports completion.
//
// Optional feature macro: MMIO_TIMEOUT_EN
//   defined   : BUSY is bounded by TIMEOUT_CYCLES. A write still pending after
//               that many BUSY cycles is retired anyway, and timeout_error_o
//               is set. It stays set until reset.
//   undefined : BUSY waits for completion indefinitely; timeout_error_o = 0.
//
// Handshake: a request is offered by holding req_valid_i with req_* stable
// while stall_o is high. The device sees mmio_enable_o held high with stable
// mmio_addr_o/mmio_w_data_o/mmio_width_o until it raises
// mmio_write_complete_i for one or more cycles. The first cycle in which both
// are high retires the write. Completion is ignored while mmio_enable_o is low.
//
// Ports
//   clock_i                single clock, all state updates on posedge
//   reset_i                synchronous, active-high reset
//   req_valid_i            stage 4 holds a valid store
//   req_addr_i [XLEN]      stage 4 effective address
//   req_w_data_i [XLEN]    stage 4 store value
//   req_width_i [2]        store width code
//   mmio_write_complete_i  device accepted the current write
//   mmio_enable_o          MMIO write strobe, held until completion
//   mmio_addr_o [XLEN]     captured address
//   mmio_w_data_o [XLEN]   captured data
//   mmio_width_o [2]       captured width
//   stall_o                hold pipeline stages 1-4
//   req_done_o             one-cycle pulse: MMIO write retired
//   timeout_error_o        sticky: a write was force-retired by timeout
//   completed_count_o [16] retired MMIO writes, wraps at 16 bits
//   state_o [2]            current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// -----------------------------------------------------------------------------
module mmio_stall_controller #(
    parameter int unsigned     XLEN           = 32,
    parameter logic [XLEN-1:0] MMIO_BASE      = 'h0000_0000,
    parameter logic [XLEN-1:0] MMIO_SIZE      = 'h0001_0000,
    parameter int unsigned     TIMEOUT_CYCLES = 256
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            req_valid_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_w_data_i,
    input  logic [1:0]      req_width_i,
    input  logic            mmio_write_complete_i,
    output logic            mmio_enable_o,
    output logic [XLEN-1:0] mmio_addr_o,
    output logic [XLEN-1:0] mmio_w_data_o,
    output logic [1:0]      mmio_width_o,
    output logic            stall_o,
    output logic            req_done_o,
    output logic            timeout_error_o,
    output logic [15:0]     completed_count_o,
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [1:0]      width_q, width_d;
    logic [15:0]     count_q, count_d;

    // Offset subtraction wraps, so the compare is a single unsigned test.
    // Addresses below the base wrap to large offsets and miss the window.
    logic [XLEN-1:0] win_offset;
    logic            in_window;

    assign win_offset = req_addr_i - MMIO_BASE;
    assign in_window  = (win_offset < MMIO_SIZE);

`ifdef MMIO_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    // The counter holds k-1 during the k-th BUSY cycle. The last allowed
    // BUSY cycle is therefore the one where it equals TIMEOUT_CYCLES-1.
    localparam logic [CW-1:0] BUSY_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] busy_cnt_q, busy_cnt_d;
    logic          terr_q, terr_d;
    logic          timeout_hit;

    assign timeout_hit = (busy_cnt_q == BUSY_LAST);
`endif

    // State and captured-request registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            width_q <= '0;
            count_q <= '0;
`ifdef MMIO_TIMEOUT_EN
            busy_cnt_q <= '0;
            terr_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            width_q <= width_d;
            count_q <= count_d;
`ifdef MMIO_TIMEOUT_EN
            busy_cnt_q <= busy_cnt_d;
            terr_q     <= terr_d;
`endif
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        width_d       = width_q;
        count_d       = count_q;
        mmio_enable_o = 1'b0;
        stall_o       = 1'b0;
        req_done_o    = 1'b0;
`ifdef MMIO_TIMEOUT_EN
        busy_cnt_d    = busy_cnt_q;
        terr_d        = terr_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                // The stall is asserted in the detect cycle itself, so the
                // store cannot leave stage 4 before it is captured.
                if (req_valid_i && in_window) begin
                    stall_o = 1'b1;
                    addr_d  = req_addr_i;
                    data_d  = req_w_data_i;
                    width_d = req_width_i;
                    state_d = ST_BUSY;
`ifdef MMIO_TIMEOUT_EN
                    busy_cnt_d = '0;
`endif
                end
            end

            ST_BUSY: begin
                mmio_enable_o = 1'b1;
                stall_o       = 1'b1;
                if (mmio_write_complete_i) begin
                    // Completion takes priority over a timeout in the same cycle.
                    state_d = ST_DONE;
                end
`ifdef MMIO_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = ST_DONE;
                    terr_d  = 1'b1;
                end else begin
                    busy_cnt_d = busy_cnt_q + 1'b1;
                end
`endif
            end

            ST_DONE: begin
                // The held store leaves stage 4 on this edge. req_* still
                // shows that store, so it is not re-examined here.
                req_done_o = 1'b1;
                count_d    = count_q + 16'd1;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mmio_addr_o       = addr_q;
    assign mmio_w_data_o     = data_q;
    assign mmio_width_o      = width_q;
    assign completed_count_o = count_q;
    assign state_o           = state_q;

`ifdef MMIO_TIMEOUT_EN
    assign timeout_error_o = terr_q;
`else
    assign timeout_error_o = 1'b0;
`endif

endmodule
